// File: rtl/channel_access_ctrl_pkg.sv
// Shared types and constants for the time-division channel access controller.
// State encodings are fixed constants so gate-level dumps decode the same way.
package channel_access_ctrl_pkg;

  localparam int SYM_W = 9;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TX    = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    TX    = ST_TX,
    GUARD = ST_GUARD
  } state_e;

  // Counter width for a range 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/channel_access_ctrl_rr_pick.sv
// Combinational round-robin select: scans ptr+1, ptr+2, ... modulo NREQ and
// returns the first set request as a one-hot vector and as an index.
module channel_access_ctrl_rr_pick
  import channel_access_ctrl_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = cnt_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    // k = NREQ wraps back to ptr itself, so the last owner is checked last.
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NREQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/channel_access_ctrl.sv
// Time-division access controller: round-robin bursts of up to FRAME_LEN
// symbols, each followed by GUARD_LEN noise-only symbols, on the symbol grid.
module channel_access_ctrl
  import channel_access_ctrl_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int FRAME_LEN = 8,
  parameter int GUARD_LEN = 2,
  parameter int SYM_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SYM_W-1:0] tx_data,
  output logic [NREQ-1:0]      grant,
  output logic                 is_transmit,
  output logic                 rest,
  output logic [SYM_W-1:0]     channel_data,
  output logic                 sym_strobe,
  output logic                 frame_done
);

  localparam int IDX_W = cnt_width(NREQ);
  localparam int SC_W  = cnt_width(FRAME_LEN);
  localparam int GC_W  = cnt_width(GUARD_LEN);
  localparam int DIV_W = cnt_width(SYM_DIV);

  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(FRAME_LEN - 1);
  localparam logic [GC_W-1:0]  GC_LAST  = GC_W'(GUARD_LEN - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SYM_DIV - 1);

  state_e           state;
  logic [DIV_W-1:0] div;
  logic [SC_W-1:0]  sym_cnt;
  logic [GC_W-1:0]  guard_cnt;
  logic [IDX_W-1:0] rr_ptr;

  logic [NREQ-1:0]  pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             burst_end;

  channel_access_ctrl_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req (req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign sym_strobe = (div == DIV_LAST);

  // During TX rr_ptr holds the current owner's index.
  assign burst_end  = !req[rr_ptr] || (sym_cnt == SC_LAST);
  assign frame_done = sym_strobe && (state == TX) && burst_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      div         <= '0;
      sym_cnt     <= '0;
      guard_cnt   <= '0;
      rr_ptr      <= IDX_W'(NREQ - 1);
      grant       <= '0;
      is_transmit <= 1'b0;
      rest        <= 1'b0;
    end else begin
      div <= sym_strobe ? '0 : div + DIV_W'(1);
      if (sym_strobe) begin
        case (state)
          IDLE: begin
            if (pick_any) begin
              state       <= TX;
              grant       <= pick_gnt;
              rr_ptr      <= pick_idx;
              sym_cnt     <= '0;
              is_transmit <= 1'b1;
            end
          end
          TX: begin
            if (burst_end) begin
              state       <= GUARD;
              guard_cnt   <= '0;
              grant       <= '0;
              is_transmit <= 1'b0;
              rest        <= 1'b1;
            end else begin
              sym_cnt <= sym_cnt + SC_W'(1);
            end
          end
          GUARD: begin
            if (guard_cnt == GC_LAST) begin
              rest <= 1'b0;
              if (pick_any) begin
                state       <= TX;
                grant       <= pick_gnt;
                rr_ptr      <= pick_idx;
                sym_cnt     <= '0;
                is_transmit <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else begin
              guard_cnt <= guard_cnt + GC_W'(1);
            end
          end
          default: begin
            state       <= IDLE;
            grant       <= '0;
            is_transmit <= 1'b0;
            rest        <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    channel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) channel_data = channel_data | tx_data[i*SYM_W +: SYM_W];
    end
  end

endmodule

// File: tb/tb_channel_access_ctrl.sv
// Directed bench for channel_access_ctrl with default parameters
// (NREQ=2, FRAME_LEN=8, GUARD_LEN=2, SYM_DIV=4).
module tb_channel_access_ctrl;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [17:0] tx_data;
  logic [1:0]  grant;
  logic        is_transmit;
  logic        rest;
  logic [8:0]  channel_data;
  logic        sym_strobe;
  logic        frame_done;

  int tests;
  int fails;

  channel_access_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .tx_data      (tx_data),
    .grant        (grant),
    .is_transmit  (is_transmit),
    .rest         (rest),
    .channel_data (channel_data),
    .sym_strobe   (sym_strobe),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse reset and return at the negedge that is clock index 0 after release.
  task automatic start(input logic [1:0] r);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    req   = r;
  endtask

  task automatic test_reset();
    start(2'b00);
    tests++;
    if ({grant, is_transmit, rest, frame_done, sym_strobe, channel_data} !== 15'd0) begin
      fails++;
      $display("FAIL reset_state got=%h exp=0",
               {grant, is_transmit, rest, frame_done, sym_strobe, channel_data});
    end
  endtask

  task automatic test_idle();
    logic [4:0] got, exp;
    start(2'b00);
    for (int cyc = 0; cyc < 40; cyc++) begin
      exp = {2'b00, 1'b0, 1'b0, 1'((cyc % 4) == 3)};
      got = {grant, is_transmit, rest, sym_strobe};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL idle cyc=%0d got=%b exp=%b", cyc, got, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_full_burst();
    logic [14:0] got, exp;
    logic tx, rs;
    tx_data = {9'h1AA, 9'h005};
    start(2'b01);
    for (int cyc = 0; cyc < 48; cyc++) begin
      tx  = (cyc >= 4 && cyc <= 35) || (cyc >= 44);
      rs  = (cyc >= 36 && cyc <= 43);
      exp = {tx ? 2'b01 : 2'b00, tx, rs, 1'(cyc == 35), 1'((cyc % 4) == 3),
             tx ? 9'h005 : 9'h000};
      got = {grant, is_transmit, rest, frame_done, sym_strobe, channel_data};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL full_burst cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_early_release();
    logic [14:0] got, exp;
    logic tx, rs;
    tx_data = {9'h1AA, 9'h0C3};
    start(2'b01);
    for (int cyc = 0; cyc < 32; cyc++) begin
      if (cyc == 12) req = 2'b00;
      tx  = (cyc >= 4 && cyc <= 15);
      rs  = (cyc >= 16 && cyc <= 23);
      exp = {tx ? 2'b01 : 2'b00, tx, rs, 1'(cyc == 15), 1'((cyc % 4) == 3),
             tx ? 9'h0C3 : 9'h000};
      got = {grant, is_transmit, rest, frame_done, sym_strobe, channel_data};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL early_release cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    logic [14:0] got, exp;
    logic tx, rs, fd;
    logic [1:0] g;
    logic [8:0] d;
    int off, b;
    tx_data = {9'h1AA, 9'h005};
    start(2'b11);
    for (int cyc = 0; cyc < 160; cyc++) begin
      tx = 1'b0; rs = 1'b0; fd = 1'b0; g = 2'b00; d = 9'h000;
      if (cyc >= 4) begin
        off = (cyc - 4) % 40;
        b   = (cyc - 4) / 40;
        tx  = (off < 32);
        rs  = (off >= 32);
        fd  = (off == 31);
        if (tx) begin
          g = (b % 2 == 0) ? 2'b01 : 2'b10;
          d = (b % 2 == 0) ? 9'h005 : 9'h1AA;
        end
      end
      exp = {g, tx, rs, fd, 1'((cyc % 4) == 3), d};
      got = {grant, is_transmit, rest, frame_done, sym_strobe, channel_data};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL round_robin cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_tx();
    logic [14:0] got;
    logic [1:0]  g_exp;
    tx_data = {9'h1AA, 9'h005};
    start(2'b11);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    got = {grant, is_transmit, rest, frame_done, sym_strobe, channel_data};
    tests++;
    if (got !== 15'd0) begin
      fails++;
      $display("FAIL reset_mid_tx_clear got=%h exp=0", got);
    end
    reset = 1'b0;
    for (int cyc = 0; cyc < 9; cyc++) begin
      g_exp = (cyc >= 4) ? 2'b01 : 2'b00;
      tests++;
      if (grant !== g_exp || is_transmit !== (cyc >= 4)) begin
        fails++;
        $display("FAIL reset_mid_tx_regrant cyc=%0d got=%b/%b exp=%b/%b",
                 cyc, grant, is_transmit, g_exp, cyc >= 4);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_off_strobe();
    start(2'b00);
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc == 4) req = 2'b10;
      if (cyc == 6) req = 2'b00;
      tests++;
      if (grant !== 2'b00 || is_transmit !== 1'b0 || rest !== 1'b0) begin
        fails++;
        $display("FAIL off_strobe cyc=%0d got=%b/%b/%b exp=00/0/0",
                 cyc, grant, is_transmit, rest);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset   = 1'b1;
    req     = 2'b00;
    tx_data = '0;
    test_reset();
    test_idle();
    test_full_burst();
    test_early_release();
    test_round_robin();
    test_reset_mid_tx();
    test_off_strobe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
